// File: rtl/ysyx_24080006_pkg.sv
// Constants shared by the WBU and its register file: CSR addresses, the ecall cause code and the WBU state encoding.
package ysyx_24080006_pkg;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

  localparam int unsigned MCAUSE_ECALL_M = 11;

  typedef logic [1:0] wbu_state_t;
  localparam wbu_state_t WBU_IDLE     = 2'd0;
  localparam wbu_state_t WBU_COMMIT   = 2'd1;
  localparam wbu_state_t WBU_REDIRECT = 2'd2;

endpackage

// File: rtl/ysyx_24080006_regfile.sv
// GPR array: one write port, two combinational read ports, x0 reads as zero.
// Writes land at the clock edge; reads see current state only, with no bypass.
module ysyx_24080006_regfile
  import ysyx_24080006_pkg::*;
#(
  parameter int NR_REG = 16,
  parameter int XLEN   = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            we,
  input  logic [3:0]      waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [3:0]      raddr1,
  output logic [XLEN-1:0] rdata1,
  input  logic [3:0]      raddr2,
  output logic [XLEN-1:0] rdata2
);

  logic [XLEN-1:0] regs_q [NR_REG];
  logic [XLEN-1:0] regs_d [NR_REG];

  always_comb begin
    regs_d = regs_q;
    if (we && (waddr != 4'd0) && (int'(waddr) < NR_REG)) begin
      regs_d[waddr] = wdata;
    end
    regs_d[0] = '0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NR_REG; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  assign rdata1 = ((raddr1 != 4'd0) && (int'(raddr1) < NR_REG)) ? regs_q[raddr1] : '0;
  assign rdata2 = ((raddr2 != 4'd0) && (int'(raddr2) < NR_REG)) ? regs_q[raddr2] : '0;

endmodule

// File: rtl/ysyx_24080006_wbu.sv
// Write-back unit: IDLE accepts one LSU result, COMMIT updates GPR/CSR state, REDIRECT holds the fetch PC until the IFU takes it.
// Redirect is valid 2 cycles after the LSU handshake; YSYX_24080006_WBU_MINSTRET_EN adds a 64-bit minstret counter.
module ysyx_24080006_wbu
  import ysyx_24080006_pkg::*;
#(
  parameter int NR_REG = 16,
  parameter int XLEN   = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            lsu_valid,
  output logic            lsu_ready,
  input  logic [XLEN-1:0] lsu_alu_res,
  input  logic [XLEN-1:0] lsu_dnpc,
  input  logic [XLEN-1:0] lsu_pc,
  input  logic [3:0]      lsu_rd_addr,
  input  logic            lsu_wb,
  input  logic [11:0]     lsu_csr_addr,
  input  logic            lsu_csr_we,
  input  logic [XLEN-1:0] lsu_csr_wdata,
  input  logic            lsu_ecall,
  input  logic            lsu_jump,
  input  logic            lsu_branch,
  output logic            ifu_valid,
  input  logic            ifu_ready,
  output logic [XLEN-1:0] ifu_dnpc,
  input  logic [3:0]      rs1_addr,
  input  logic [3:0]      rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  input  logic [11:0]     csr_raddr,
  output logic [XLEN-1:0] csr_rdata
);

  wbu_state_t      state_q, state_d;
  logic [XLEN-1:0] alu_q, alu_d, dnpc_q, dnpc_d, pc_q, pc_d, csr_wdata_q, csr_wdata_d;
  logic [3:0]      rd_q, rd_d;
  logic [11:0]     csr_addr_q, csr_addr_d;
  logic            wb_q, wb_d, csr_we_q, csr_we_d, ecall_q, ecall_d;
  logic            ifu_valid_q, ifu_valid_d;
  logic [XLEN-1:0] ifu_dnpc_q, ifu_dnpc_d;
  logic [XLEN-1:0] mstatus_q, mstatus_d, mtvec_q, mtvec_d, mepc_q, mepc_d, mcause_q, mcause_d;
  logic            commit;
  logic            unused_info;

  assign commit      = (state_q == WBU_COMMIT);
  assign lsu_ready   = (state_q == WBU_IDLE);
  assign ifu_valid   = ifu_valid_q;
  assign ifu_dnpc    = ifu_dnpc_q;
  assign unused_info = lsu_jump ^ lsu_branch;

  always_comb begin
    state_d     = state_q;
    alu_d       = alu_q;
    dnpc_d      = dnpc_q;
    pc_d        = pc_q;
    rd_d        = rd_q;
    wb_d        = wb_q;
    csr_addr_d  = csr_addr_q;
    csr_we_d    = csr_we_q;
    csr_wdata_d = csr_wdata_q;
    ecall_d     = ecall_q;
    ifu_valid_d = ifu_valid_q;
    ifu_dnpc_d  = ifu_dnpc_q;
    mstatus_d   = mstatus_q;
    mtvec_d     = mtvec_q;
    mepc_d      = mepc_q;
    mcause_d    = mcause_q;
    case (state_q)
      WBU_IDLE: begin
        if (lsu_valid) begin
          alu_d       = lsu_alu_res;
          dnpc_d      = lsu_dnpc;
          pc_d        = lsu_pc;
          rd_d        = lsu_rd_addr;
          wb_d        = lsu_wb;
          csr_addr_d  = lsu_csr_addr;
          csr_we_d    = lsu_csr_we;
          csr_wdata_d = lsu_csr_wdata;
          ecall_d     = lsu_ecall;
          state_d     = WBU_COMMIT;
        end
      end
      WBU_COMMIT: begin
        if (csr_we_q) begin
          case (csr_addr_q)
            CSR_MSTATUS: mstatus_d = csr_wdata_q;
            CSR_MTVEC:   mtvec_d   = csr_wdata_q;
            CSR_MEPC:    mepc_d    = csr_wdata_q;
            CSR_MCAUSE:  mcause_d  = csr_wdata_q;
            default:     ;
          endcase
        end
        // ecall is applied last so it overrides a same-commit write to mepc/mcause
        if (ecall_q) begin
          mepc_d   = pc_q;
          mcause_d = XLEN'(MCAUSE_ECALL_M);
        end
        ifu_dnpc_d  = ecall_q ? mtvec_q : dnpc_q;
        ifu_valid_d = 1'b1;
        state_d     = WBU_REDIRECT;
      end
      WBU_REDIRECT: begin
        if (ifu_ready) begin
          ifu_valid_d = 1'b0;
          state_d     = WBU_IDLE;
        end
      end
      default: state_d = WBU_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= WBU_IDLE;
      alu_q       <= '0;
      dnpc_q      <= '0;
      pc_q        <= '0;
      rd_q        <= '0;
      wb_q        <= 1'b0;
      csr_addr_q  <= '0;
      csr_we_q    <= 1'b0;
      csr_wdata_q <= '0;
      ecall_q     <= 1'b0;
      ifu_valid_q <= 1'b0;
      ifu_dnpc_q  <= '0;
      mstatus_q   <= '0;
      mtvec_q     <= '0;
      mepc_q      <= '0;
      mcause_q    <= '0;
    end else begin
      state_q     <= state_d;
      alu_q       <= alu_d;
      dnpc_q      <= dnpc_d;
      pc_q        <= pc_d;
      rd_q        <= rd_d;
      wb_q        <= wb_d;
      csr_addr_q  <= csr_addr_d;
      csr_we_q    <= csr_we_d;
      csr_wdata_q <= csr_wdata_d;
      ecall_q     <= ecall_d;
      ifu_valid_q <= ifu_valid_d;
      ifu_dnpc_q  <= ifu_dnpc_d;
      mstatus_q   <= mstatus_d;
      mtvec_q     <= mtvec_d;
      mepc_q      <= mepc_d;
      mcause_q    <= mcause_d;
    end
  end

`ifdef YSYX_24080006_WBU_MINSTRET_EN
  logic [63:0] minstret_q, minstret_d;

  always_comb begin
    minstret_d = minstret_q + (commit ? 64'd1 : 64'd0);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) minstret_q <= '0;
    else        minstret_q <= minstret_d;
  end
`endif

  always_comb begin
    csr_rdata = '0;
    case (csr_raddr)
      CSR_MSTATUS:   csr_rdata = mstatus_q;
      CSR_MTVEC:     csr_rdata = mtvec_q;
      CSR_MEPC:      csr_rdata = mepc_q;
      CSR_MCAUSE:    csr_rdata = mcause_q;
`ifdef YSYX_24080006_WBU_MINSTRET_EN
      CSR_MINSTRET:  csr_rdata = XLEN'(minstret_q[31:0]);
      CSR_MINSTRETH: csr_rdata = XLEN'(minstret_q[63:32]);
`endif
      default:       csr_rdata = '0;
    endcase
  end

  ysyx_24080006_regfile #(
    .NR_REG (NR_REG),
    .XLEN   (XLEN)
  ) u_regfile (
    .clock  (clock),
    .reset  (reset),
    .we     (commit && wb_q),
    .waddr  (rd_q),
    .wdata  (alu_q),
    .raddr1 (rs1_addr),
    .rdata1 (rs1_data),
    .raddr2 (rs2_addr),
    .rdata2 (rs2_data)
  );

endmodule

// File: doc/ysyx_24080006_wbu.md
YSYX_24080006_WBU -- requirements
Module: ysyx_24080006_wbu

Interface
- REQ-001 SHALL have parameter NR_REG, default 16, meaning the number of architectural GPRs (RV32E).
- REQ-002 SHALL have parameter XLEN, default 32, meaning the datapath width.
- REQ-003 SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
- REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset.
- REQ-005 SHALL have port lsu_valid, input, 1, LSU result valid.
- REQ-006 SHALL have port lsu_ready, output, 1, WBU accepts an LSU result.
- REQ-007 SHALL have ports lsu_alu_res, lsu_dnpc and lsu_pc, input, XLEN each, meaning GPR write data, next PC and instruction PC.
- REQ-008 SHALL have ports lsu_rd_addr, input, 4, destination GPR, and lsu_wb, input, 1, GPR write enable.
- REQ-009 SHALL have ports lsu_csr_addr, input, 12, CSR address; lsu_csr_we, input, 1, CSR write enable; lsu_csr_wdata, input, XLEN, CSR write data.
- REQ-010 SHALL have ports lsu_ecall, input, 1, environment call; lsu_jump and lsu_branch, input, 1 each, informational only.
- REQ-011 SHALL have ports ifu_valid, output, 1, redirect valid; ifu_ready, input, 1, IFU accepts the redirect; ifu_dnpc, output, XLEN, fetch PC.
- REQ-012 SHALL have ports rs1_addr and rs2_addr, input, 4 each, and rs1_data and rs2_data, output, XLEN each, combinational GPR reads for the IDU.
- REQ-013 SHALL have ports csr_raddr, input, 12, and csr_rdata, output, XLEN, combinational CSR read for the EXU.

Function
- REQ-014 SHALL implement the FSM IDLE -> COMMIT -> REDIRECT -> IDLE.
- REQ-015 SHALL drive lsu_ready=1 only in IDLE; on lsu_valid&&lsu_ready, latch all lsu_* fields and enter COMMIT on the next edge.
- REQ-016 SHALL spend exactly one cycle in COMMIT.
- REQ-017 SHALL, at the COMMIT edge, write latched alu_res to GPR[rd_addr] if wb=1 and rd_addr!=0; GPR0 SHALL always read 0.
- REQ-018 SHALL, at the COMMIT edge, write csr_wdata to the addressed CSR if csr_we=1; the writable CSRs are mstatus 0x300, mtvec 0x305, mepc 0x341 and mcause 0x342. Writes to other addresses are ignored; reads of other addresses return 0.
- REQ-019 SHALL, at the COMMIT edge when ecall=1, set mepc<=pc and mcause<=11; ecall takes precedence over csr_we to mepc or mcause.
- REQ-020 SHALL, at the COMMIT edge, set ifu_dnpc<=(ecall ? mtvec : dnpc), using mtvec before this commit, and set ifu_valid<=1.
- REQ-021 SHALL hold ifu_valid and ifu_dnpc stable in REDIRECT until ifu_ready=1, then clear ifu_valid and return to IDLE.
- REQ-022 SHALL give a minimum commit-to-redirect-accept latency of 2 cycles after the LSU handshake.
- REQ-023 SHALL read GPRs and CSRs from current state without bypass; a write is visible the cycle after COMMIT.
- REQ-024 SHALL treat rd_addr values >= NR_REG as no-write.

Reset
- REQ-025 SHALL, while reset=0, immediately force state=IDLE, lsu_ready=1 (derived from state), ifu_valid=0, ifu_dnpc=0, all GPRs=0, and all CSRs=0.
- REQ-026 SHALL, on reset asserted mid-COMMIT or mid-REDIRECT, abandon the instruction without a partial GPR or CSR write after reset.

Configuration
- REQ-027 SHALL, with YSYX_24080006_WBU_MINSTRET_EN defined, keep a 64-bit minstret counter incremented once per COMMIT, readable at CSR 0xB02 (low) and 0xB82 (high), and reset to 0.
- REQ-028 SHALL, without YSYX_24080006_WBU_MINSTRET_EN, build no counter and return 0 for reads of 0xB02 and 0xB82.

Structure
- REQ-029 SHALL place the CSR address constants, MCAUSE_ECALL_M=11, and the WBU state enum in the shared package ysyx_24080006_pkg.
- REQ-030 SHALL implement the GPR array as sub-module ysyx_24080006_regfile, with 1 write port, 2 combinational read ports, and x0 hardwired to 0.

Verification
- REQ-031 SHALL cover: ALU result wb=1, rd=5, alu_res=0xDEADBEEF -> the cycle after COMMIT, rs1_addr=5 reads 0xDEADBEEF, and ifu_dnpc=lsu_dnpc.
- REQ-032 SHALL cover: wb=1, rd=0, alu_res=0x1234 -> rs1_data for x0 stays 0.
- REQ-033 SHALL cover: csr_we=1 to 0x305 with 0x8000_0100, then ecall at pc=0x8000_0040 -> mepc=0x8000_0040, mcause=11, ifu_dnpc=0x8000_0100.
- REQ-034 SHALL cover: ifu_ready held 0 for 5 cycles -> ifu_valid and ifu_dnpc stable, lsu_ready=0, and a second lsu_valid is not accepted.
- REQ-035 SHALL cover: reset pulsed low during REDIRECT -> ifu_valid=0 immediately, state IDLE, and GPR reads 0 after release.
- REQ-036 SHALL cover: with MINSTRET_EN, 3 commits -> CSR 0xB02 reads 3; without MINSTRET_EN -> CSR 0xB02 reads 0.
